// File: rtl/ins_fetcher_pkg.sv
// Shared fetch-side types, opcode constants and instruction-queue encodings.
// JAL_PREDICT_EN adds the J-immediate decode helper used by fetch predecode.
package ins_fetcher_pkg;

  typedef logic [31:0] INS_TYPE;
  typedef logic [31:0] ADDR_TYPE;

  localparam int OPCODE_RANGE = 7;
  localparam logic [OPCODE_RANGE-1:0] OPCODE_JAL = 7'b1101111;
  localparam INS_TYPE ZERO_WORD = 32'h0000_0000;
  localparam ADDR_TYPE PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IQ_IDLE = 2'd0,
    IQ_BUSY = 2'd1,
    IQ_DROP = 2'd2
  } iq_state_e;

  typedef struct packed {
    ADDR_TYPE pc;
    INS_TYPE  ins;
  } iq_entry_t;

`ifdef JAL_PREDICT_EN
  function automatic ADDR_TYPE jal_imm(input INS_TYPE w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction
`endif

endpackage

// File: rtl/ins_fetcher_queue.sv
// Instruction queue: circular buffer of {pc, word} with flush.
// Flush wins over push and pop in the same cycle.
module ins_queue
  import ins_fetcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t      mem [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: one outstanding memory request feeding a small queue.
// Define JAL_PREDICT_EN to follow JAL targets at fetch time.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int       IQ_DEPTH = 4,
  parameter ADDR_TYPE RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  iq_state_e state;
  iq_state_e state_nx;
  ADDR_TYPE  fetch_pc;
  ADDR_TYPE  req_pc;
  ADDR_TYPE  next_pc;

  logic      redir;
  logic      req_fire;
  logic      push;
  logic      pop;
  logic      q_full;
  logic      q_empty;
  iq_entry_t q_head;
  iq_entry_t q_in;

  // Redirect is held off while stalled; responses are not.
  assign redir    = redirect_valid && rdy;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign push     = (state == IQ_BUSY) && mem_resp_valid && !redir;
  assign pop      = inst_valid && inst_ready;

  assign mem_req_valid = rst_n && (state == IQ_IDLE) && rdy
                         && !redirect_valid && !q_full;
  assign mem_req_addr  = fetch_pc;

  assign inst_valid = rst_n && !q_empty && !redirect_valid && rdy;
  assign inst       = q_head.ins;
  assign inst_pc    = q_head.pc;

  assign q_in.pc  = req_pc;
  assign q_in.ins = mem_resp_data;

  always_comb begin
    next_pc = req_pc + PC_STEP;
`ifdef JAL_PREDICT_EN
    if (mem_resp_data[OPCODE_RANGE-1:0] == OPCODE_JAL) begin
      next_pc = req_pc + jal_imm(mem_resp_data);
    end
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IQ_IDLE: begin
        if (!redir && req_fire) state_nx = IQ_BUSY;
      end
      IQ_BUSY: begin
        if (mem_resp_valid) state_nx = IQ_IDLE;
        else if (redir)     state_nx = IQ_DROP;
      end
      IQ_DROP: begin
        if (mem_resp_valid) state_nx = IQ_IDLE;
      end
      default: state_nx = IQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IQ_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_nx;
      if (redir) begin
        fetch_pc <= redirect_pc;
      end else if (push) begin
        fetch_pc <= next_pc;
      end
      if (req_fire) begin
        req_pc <= fetch_pc;
      end
    end
  end

  ins_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: fetch, fill, redirect, stall, wrap, reset.
// Expected values are hand-derived constants.
module tb_ins_fetcher;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] jal_next;

  ins_fetcher #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue at addr (already visible), answer the next cycle with word.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, addr);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = word;
    #1;
    chk("busy_noreq", {31'b0, mem_req_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    `ifdef JAL_PREDICT_EN
    jal_next = 32'h30;
    `else
    jal_next = 32'h24;
    `endif
    #2;
    chk("rst_req", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_iv", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Sequential fetch into a stalled decoder
    fetch(32'h0, 32'h0000_0013);
    chk("first_iv", {31'b0, inst_valid}, 32'd1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_ins", inst, 32'h0000_0013);
    fetch(32'h4, 32'h0000_0093);
    fetch(32'h8, 32'h0000_0113);
    fetch(32'hC, 32'h0000_0193);
    chk("full_noreq", {31'b0, mem_req_valid}, 32'd0);
    tick();
    chk("full_hold", {31'b0, mem_req_valid}, 32'd0);
    chk("full_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    #1;
    chk("deq_iv", {31'b0, inst_valid}, 32'd1);
    tick();
    inst_ready = 1'b0;
    #1;
    chk("deq_head", inst_pc, 32'h4);
    chk("deq_ins", inst, 32'h0000_0093);
    chk("deq_req", {31'b0, mem_req_valid}, 32'd1);
    chk("deq_addr", mem_req_addr, 32'h10);

    // Redirect while BUSY: next response dropped
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("rd_iv", {31'b0, inst_valid}, 32'd0);
    chk("rd_req", {31'b0, mem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drop_iv", {31'b0, inst_valid}, 32'd0);
    chk("drop_req", {31'b0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("drop_iv2", {31'b0, inst_valid}, 32'd0);
    chk("drop_nreq", {31'b0, mem_req_valid}, 32'd1);
    chk("drop_addr", mem_req_addr, 32'h100);

    // Redirect coincident with response: word discarded, back to IDLE
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0013;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("co_iv", {31'b0, inst_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("co_req", {31'b0, mem_req_valid}, 32'd1);
    chk("co_addr", mem_req_addr, 32'h100);
    chk("co_iv2", {31'b0, inst_valid}, 32'd0);

    // JAL predecode
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    #1;
    fetch(32'h20, 32'h0100_006F);
    chk("jal_pc", inst_pc, 32'h20);
    chk("jal_ins", inst, 32'h0100_006F);
    chk("jal_addr", mem_req_addr, jal_next);

    // Stall with response arriving in BUSY
    tick();
    rdy = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0ABC;
    #1;
    chk("st_req", {31'b0, mem_req_valid}, 32'd0);
    chk("st_iv", {31'b0, inst_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("st_req2", {31'b0, mem_req_valid}, 32'd0);
    chk("st_iv2", {31'b0, inst_valid}, 32'd0);
    tick();
    tick();
    rdy = 1'b1;
    mem_req_ready = 1'b0;
    #1;
    chk("st_iv3", {31'b0, inst_valid}, 32'd1);
    chk("st_head", inst_pc, 32'h20);
    chk("st_req3", {31'b0, mem_req_valid}, 32'd1);
    chk("st_addr", mem_req_addr, jal_next + 32'd4);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("st_pc2", inst_pc, jal_next);
    chk("st_ins2", inst, 32'h0000_0ABC);

    // PC wrap
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    fetch(32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap_addr", mem_req_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Asynchronous reset mid-BUSY
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'b0, mem_req_valid}, 32'd0);
    chk("ar_iv", {31'b0, inst_valid}, 32'd0);
    chk("ar_inst", inst, 32'd0);
    chk("ar_pc", inst_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ar_req2", {31'b0, mem_req_valid}, 32'd1);
    chk("ar_addr", mem_req_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ins_fetcher.md
INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rdy  in  1  global enable; low = hold all state.
REQ-006 SHALL have port mem_req_valid  out  1  fetch request to memory controller.
REQ-007 SHALL have port mem_req_addr  out  32  word-aligned fetch address.
REQ-008 SHALL have port mem_req_ready  in  1  controller accepts request this cycle.
REQ-009 SHALL have port mem_resp_valid  in  1  fetched word present.
REQ-010 SHALL have port mem_resp_data  in  32  fetched instruction word.
REQ-011 SHALL have port inst_valid  out  1  queue head valid toward decoder.
REQ-012 SHALL have port inst  out  32  queue-head instruction, fed to decoder inst input.
REQ-013 SHALL have port inst_pc  out  32  PC of queue-head instruction.
REQ-014 SHALL have port inst_ready  in  1  downstream consumes head this cycle.
REQ-015 SHALL have port redirect_valid  in  1  flush and restart fetch (mispredict/jump resolve).
REQ-016 SHALL have port redirect_pc  in  32  new fetch PC.

Function
REQ-017 SHALL implement FSM IDLE, BUSY, DROP; at most one outstanding memory request.
REQ-018 SHALL assert mem_req_valid iff state==IDLE, rdy, !redirect_valid, and count+0 < IQ_DEPTH; mem_req_addr = fetch_pc.
REQ-019 SHALL go IDLE->BUSY when mem_req_valid && mem_req_ready, latching req_pc = fetch_pc.
REQ-020 SHALL in BUSY on mem_resp_valid (no redirect) enqueue {req_pc, mem_resp_data}, update fetch_pc per REQ-030/031, go IDLE.
REQ-021 SHALL transfer head when inst_valid && inst_ready; enqueue and dequeue in same cycle both take effect, count unchanged.
REQ-022 SHALL drive inst_valid = (count!=0) && !redirect_valid && rdy; inst/inst_pc from registered queue head (response to visible output: 1 cycle when empty).
REQ-023 SHALL on redirect_valid: clear queue, fetch_pc <= redirect_pc; IDLE stays IDLE; BUSY without same-cycle response -> DROP; BUSY with same-cycle response -> IDLE, response discarded; DROP stays DROP.
REQ-024 SHALL in DROP discard the next mem_resp_valid word and return to IDLE.
REQ-025 SHALL give redirect priority over enqueue, dequeue and request issue in the same cycle.
REQ-026 SHALL, while rdy low, hold FSM, queue, fetch_pc; mem_req_valid and inst_valid low; a mem_resp_valid arriving in BUSY/DROP is still consumed (never lost).
REQ-027 SHALL wrap queue pointers modulo IQ_DEPTH; count range 0..IQ_DEPTH; never enqueue when full (guaranteed by REQ-018 slot reservation).
REQ-028 SHALL compute all PC arithmetic modulo 2^32 (0xFFFFFFFC + 4 = 0).

Reset
REQ-029 SHALL on rst_n low asynchronously set: state IDLE, fetch_pc RESET_PC, req_pc 0, queue empty, inst 0, inst_pc 0, inst_valid 0, mem_req_valid 0.

Configuration
REQ-030 SHALL with JAL_PREDICT_EN defined predecode the response: opcode==JAL -> fetch_pc <= req_pc + sign-extended J-immediate (imm[20:1] from inst[31],[19:12],[20],[30:21], imm[0]=0); otherwise req_pc+4.
REQ-031 SHALL without JAL_PREDICT_EN always set fetch_pc <= req_pc + 4; no predecode logic present.

Structure
REQ-032 SHALL take INS_TYPE, ADDR_TYPE, OPCODE_RANGE, OPCODE_JAL, ZERO_WORD from the shared defines package; add IQ state encodings there.
REQ-033 SHALL place the queue in sub-module ins_queue (circular buffer, head/tail/count, flush input).

Verification
REQ-034 Reset, RESET_PC=0, mem_req_ready=1, 1-cycle responses 0x00000013 -> requests at 0,4,8,12; inst_valid first high 1 cycle after first response, inst_pc 0.
REQ-035 inst_ready=0, IQ_DEPTH=4 -> exactly 4 enqueued, mem_req_valid low; one dequeue -> one new request at 0x10.
REQ-036 redirect_valid with redirect_pc 0x100 while BUSY -> next response dropped, next request addr 0x100, queue empty.
REQ-037 redirect same cycle as response -> word discarded, state IDLE, next request 0x100, inst_valid low that cycle.
REQ-038 JAL_PREDICT_EN, word 0x0100006F at pc 0x20 -> next request 0x30; macro off -> 0x24.
REQ-039 rdy low 3 cycles during BUSY with response arriving -> word enqueued, no outputs asserted, resumes unchanged; rst_n low mid-BUSY -> REQ-029 values immediately.
